// File: rtl/iic_hs_tx.sv
// iic_hs_tx: source side of a 4-phase rdy/ack word handshake.
// Producer samples are queued in a small ring buffer and sent one word at a
// time: data is presented, rdy is raised, ack high ends the request, and
// ack low re-arms the source for the next word.
// Optional macro IIC_HS_TX_CNT_EN enables the completed-word counter on
// tx_cnt_o; without it tx_cnt_o is tied to zero.
module iic_hs_tx #(
  parameter int WIDTH    = 16,
  parameter int BUF_SIZE = 2,
  parameter int ACK_SYNC = 1,
  parameter int TMO_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   smp_data_i,
  input  logic               smp_valid_i,
  output logic [WIDTH-1:0]   hs_data_o,
  output logic               hs_rdy_o,
  input  logic               hs_ack_i,
  output logic [BUF_SIZE:0]  buf_level_o,
  output logic               ovf_o,
  output logic               tmo_o,
  input  logic               clr_flags_i,
  output logic [15:0]        tx_cnt_o
);

  localparam int DEPTH = 1 << BUF_SIZE;
  localparam logic [BUF_SIZE:0] PTR_ONE = {{BUF_SIZE{1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [BUF_SIZE:0]    wr_ptr;
  logic [BUF_SIZE:0]    rd_ptr;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 ack_s;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 ovf_set;
  logic                 tmo_set;
  logic                 tmo_fire;
  logic                 ack_done;

  // ---- ack conditioning stage ----
  if (ACK_SYNC != 0) begin : g_ack_sync
    logic ack_sync_p0;
    logic ack_sync_p1;

    // Two-flop synchronizer for an ack coming from another clock domain
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ack_sync_p0 <= 1'b0;
        ack_sync_p1 <= 1'b0;
      end else begin
        ack_sync_p0 <= hs_ack_i;
        ack_sync_p1 <= ack_sync_p0;
      end
    end

    assign ack_s = ack_sync_p1;
  end else begin : g_ack_direct
    assign ack_s = hs_ack_i;
  end

  // ---- buffer status and handshake decode ----
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[BUF_SIZE] != rd_ptr[BUF_SIZE]) &&
                    (wr_ptr[BUF_SIZE-1:0] == rd_ptr[BUF_SIZE-1:0]);
  // A stale ack still high in IDLE blocks the next word until it drops
  assign pop      = (state == IDLE) && !empty && !ack_s;
  assign push     = smp_valid_i && (!full || pop);
  assign ovf_set  = smp_valid_i && full && !pop;
  assign tmo_fire = &tmo_cnt;
  assign tmo_set  = tmo_fire && (((state == REQ) && !ack_s) ||
                                 ((state == REL) && ack_s));
  assign ack_done = (state == REQ) && ack_s;

  assign buf_level_o = wr_ptr - rd_ptr;

  // Buffer storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[BUF_SIZE-1:0]] <= smp_data_i;
    end
  end

  // Write pointer advances on every accepted sample, wrapping by truncation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // ---- handshake state machine ----
  // Handshake FSM: loads a word, drives rdy, tracks ack phases and timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      hs_rdy_o  <= 1'b0;
      hs_data_o <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (pop) begin
            hs_data_o <= mem[rd_ptr[BUF_SIZE-1:0]];
            rd_ptr    <= rd_ptr + PTR_ONE;
            hs_rdy_o  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s || tmo_fire) begin
            // On timeout the word is abandoned; the sink must still release ack
            hs_rdy_o <= 1'b0;
            tmo_cnt  <= '0;
            state    <= REL;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        REL: begin
          if (!ack_s) begin
            tmo_cnt <= '0;
            state   <= IDLE;
          end else if (!tmo_fire) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: begin
          hs_rdy_o <= 1'b0;
          tmo_cnt  <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Sticky status flags; a set event in the clearing cycle keeps the flag set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      tmo_o <= 1'b0;
    end else begin
      ovf_o <= ovf_set | (ovf_o & ~clr_flags_i);
      tmo_o <= tmo_set | (tmo_o & ~clr_flags_i);
    end
  end

`ifdef IIC_HS_TX_CNT_EN
  logic [15:0] tx_cnt;

  // Completed-word counter, bumped only by an acked request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt <= '0;
    end else if (ack_done) begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign tx_cnt_o = tx_cnt;
`else
  logic unused_ack_done;
  assign unused_ack_done = ack_done;
  assign tx_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_iic_hs_tx.sv
// Testbench for iic_hs_tx: directed checks on an unsynchronized-ack
// instance with a short timeout, plus a stream through a synchronized-ack
// instance driven by a simple handshaking sink.
module tb_iic_hs_tx;

`ifdef IIC_HS_TX_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Instance 0: ACK_SYNC=0, TMO_W=4
  logic [15:0] smp_data0 = '0;
  logic        smp_valid0 = 1'b0;
  logic [15:0] hs_data0;
  logic        hs_rdy0;
  logic        ack0 = 1'b0;
  logic [2:0]  level0;
  logic        ovf0;
  logic        tmo0;
  logic        clr0 = 1'b0;
  logic [15:0] tx0;
  logic        auto0 = 1'b0;
  logic        ack_frc0 = 1'b0;

  // Instance 1: ACK_SYNC=1, TMO_W=8
  logic [15:0] smp_data1 = '0;
  logic        smp_valid1 = 1'b0;
  logic [15:0] hs_data1;
  logic        hs_rdy1;
  logic        ack1 = 1'b0;
  logic [2:0]  level1;
  logic        ovf1;
  logic        tmo1;
  logic [15:0] tx1;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iic_hs_tx #(.WIDTH(16), .BUF_SIZE(2), .ACK_SYNC(0), .TMO_W(4)) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .smp_data_i  (smp_data0),
    .smp_valid_i (smp_valid0),
    .hs_data_o   (hs_data0),
    .hs_rdy_o    (hs_rdy0),
    .hs_ack_i    (ack0),
    .buf_level_o (level0),
    .ovf_o       (ovf0),
    .tmo_o       (tmo0),
    .clr_flags_i (clr0),
    .tx_cnt_o    (tx0)
  );

  iic_hs_tx #(.WIDTH(16), .BUF_SIZE(2), .ACK_SYNC(1), .TMO_W(8)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .smp_data_i  (smp_data1),
    .smp_valid_i (smp_valid1),
    .hs_data_o   (hs_data1),
    .hs_rdy_o    (hs_rdy1),
    .hs_ack_i    (ack1),
    .buf_level_o (level1),
    .ovf_o       (ovf1),
    .tmo_o       (tmo1),
    .clr_flags_i (1'b0),
    .tx_cnt_o    (tx1)
  );

  // Sink for instance 0: follows rdy when auto mode is on, else forced level
  always @(negedge clk) begin
    ack0 = auto0 ? hs_rdy0 : ack_frc0;
  end

  // Sink for instance 1: captures each word on its rdy rise, ack follows rdy
  always @(negedge clk) begin
    if (hs_rdy1 && !ack1) got_q.push_back(hs_data1);
    ack1 = hs_rdy1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_rdy",   32'(hs_rdy0), 32'd0);
    chk("rst_data",  32'(hs_data0), 32'h0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_ovf",   32'(ovf0), 32'd0);
    chk("rst_tmo",   32'(tmo0), 32'd0);
    chk("rst_tx",    32'(tx0), 32'd0);
    rst = 1'b0;
    step();

    // Two back-to-back samples, immediate ack
    auto0 = 1'b1;
    smp_valid0 = 1'b1; smp_data0 = 16'h1234;
    step();
    smp_data0 = 16'hABCD;
    step();
    smp_valid0 = 1'b0;
    chk("w1_rdy",   32'(hs_rdy0), 32'd1);
    chk("w1_data",  32'(hs_data0), 32'h1234);
    chk("w1_level", 32'(level0), 32'd1);
    step();
    chk("w1_rel_rdy",  32'(hs_rdy0), 32'd0);
    chk("w1_rel_data", 32'(hs_data0), 32'h1234);
    step();
    step();
    chk("w2_rdy",   32'(hs_rdy0), 32'd1);
    chk("w2_data",  32'(hs_data0), 32'hABCD);
    chk("w2_level", 32'(level0), 32'd0);
    step();
    step();
    chk("w2_tx",    32'(tx0), 32'(2 * CNT_ON));
    chk("w2_idle",  32'(hs_rdy0), 32'd0);

    // Overflow with ack held low
    auto0 = 1'b0; ack_frc0 = 1'b0;
    smp_valid0 = 1'b1; smp_data0 = 16'h0001;
    step();
    smp_data0 = 16'h0002;
    step();                                // REQ entered: e0
    chk("ov_req_data", 32'(hs_data0), 32'h0001);
    smp_data0 = 16'h0003; step();          // e1
    smp_data0 = 16'h0004; step();          // e2
    smp_data0 = 16'h0005; step();          // e3
    chk("ov_full_level", 32'(level0), 32'd4);
    chk("ov_not_yet",    32'(ovf0), 32'd0);
    smp_data0 = 16'h0006; step();          // e4: dropped
    smp_valid0 = 1'b0;
    chk("ov_set",       32'(ovf0), 32'd1);
    chk("ov_level",     32'(level0), 32'd4);
    clr0 = 1'b1; step();                   // e5
    clr0 = 1'b0;
    chk("ov_clr", 32'(ovf0), 32'd0);
    clr0 = 1'b1; smp_valid0 = 1'b1; smp_data0 = 16'h0007;
    step();                                // e6: set beats clear
    clr0 = 1'b0; smp_valid0 = 1'b0;
    chk("ov_set_wins", 32'(ovf0), 32'd1);
    clr0 = 1'b1; step();                   // e7
    clr0 = 1'b0;
    chk("ov_clr2", 32'(ovf0), 32'd0);

    // Timeout: counter all-ones after e15, fires at e16
    repeat (8) step();                     // e15
    chk("tmo_pre_rdy", 32'(hs_rdy0), 32'd1);
    chk("tmo_pre_flag", 32'(tmo0), 32'd0);
    step();                                // e16
    chk("tmo_rdy",  32'(hs_rdy0), 32'd0);
    chk("tmo_flag", 32'(tmo0), 32'd1);
    chk("tmo_tx",   32'(tx0), 32'(2 * CNT_ON));
    step();                                // e17: REL -> IDLE
    step();                                // e18: next word
    chk("tmo_next_rdy",   32'(hs_rdy0), 32'd1);
    chk("tmo_next_data",  32'(hs_data0), 32'h0002);
    chk("tmo_next_level", 32'(level0), 32'd3);
    auto0 = 1'b1;
    repeat (20) step();
    chk("drain_level", 32'(level0), 32'd0);
    chk("drain_rdy",   32'(hs_rdy0), 32'd0);
    chk("drain_tx",    32'(tx0), 32'(6 * CNT_ON));
    chk("drain_tmo",   32'(tmo0), 32'd1);
    clr0 = 1'b1; step();
    clr0 = 1'b0;
    chk("tmo_clr", 32'(tmo0), 32'd0);

    // Reset while in REQ
    auto0 = 1'b0; ack_frc0 = 1'b0;
    smp_valid0 = 1'b1; smp_data0 = 16'h5555;
    step();
    smp_valid0 = 1'b0;
    step();
    chk("rq_rdy",  32'(hs_rdy0), 32'd1);
    chk("rq_data", 32'(hs_data0), 32'h5555);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rq_rst_rdy",   32'(hs_rdy0), 32'd0);
    chk("rq_rst_level", 32'(level0), 32'd0);
    chk("rq_rst_tx",    32'(tx0), 32'd0);
    chk("rq_rst_data",  32'(hs_data0), 32'h0);
    smp_valid0 = 1'b1; smp_data0 = 16'h0A0A;
    step();
    smp_valid0 = 1'b0; auto0 = 1'b1;
    step();
    chk("rq_after_rdy",  32'(hs_rdy0), 32'd1);
    chk("rq_after_data", 32'(hs_data0), 32'h0A0A);
    repeat (3) step();
    chk("rq_after_tx", 32'(tx0), 32'(CNT_ON));

    // Stale ack held through reset release
    auto0 = 1'b0; ack_frc0 = 1'b1;
    rst = 1'b1; step(); step();
    rst = 1'b0;
    smp_valid0 = 1'b1; smp_data0 = 16'h0BBB;
    step();
    smp_valid0 = 1'b0;
    repeat (3) step();
    chk("stale_rdy",   32'(hs_rdy0), 32'd0);
    chk("stale_level", 32'(level0), 32'd1);
    ack_frc0 = 1'b0;
    step();
    chk("stale_go_rdy",  32'(hs_rdy0), 32'd1);
    chk("stale_go_data", 32'(hs_data0), 32'h0BBB);
    ack_frc0 = 1'b1; step();
    ack_frc0 = 1'b0; step();
    chk("stale_tx", 32'(tx0), 32'(CNT_ON));

    // Synchronized-ack stream of 32 words
    rst = 1'b1; step(); step();
    rst = 1'b0;
    got_q.delete();
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      smp_valid1 = 1'b1; smp_data1 = w;
      step();
      smp_valid1 = 1'b0;
      repeat (11) step();
    end
    for (int t = 0; t < 300 && got_q.size() < 32; t++) step();
    repeat (10) step();
    chk("st_count", 32'(got_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      if (i < got_q.size()) chk($sformatf("st_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      else chk($sformatf("st_word%0d", i), 32'hDEAD_BEEF, 32'(exp_q[i]));
    end
    chk("st_ovf",   32'(ovf1), 32'd0);
    chk("st_tmo",   32'(tmo1), 32'd0);
    chk("st_level", 32'(level1), 32'd0);
    chk("st_tx",    32'(tx1), 32'(32 * CNT_ON));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
